// File: rtl/burst_read_streamer_if.sv
// Command, memory-read and stream-write signal bundle for burst_read_streamer.
// slave is the streamer's view; master is the view of the surrounding system.
interface burst_read_streamer_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic [ADDR_WIDTH-1:0] cmdAddrIn;
  logic [LEN_WIDTH-1:0]  cmdLenIn;
  logic                  cmdValidIn;
  logic                  cmdReadyOut;
  logic                  memRdEnOut;
  logic [ADDR_WIDTH-1:0] memAddrOut;
  logic [DATA_WIDTH-1:0] memRdDataIn;
  logic [DATA_WIDTH-1:0] wrDataOut;
  logic                  wrValidOut;
  logic                  wrReadyIn;
  logic                  busyOut;
  logic                  doneOut;

  modport slave (
    input  cmdAddrIn, cmdLenIn, cmdValidIn, memRdDataIn, wrReadyIn,
    output cmdReadyOut, memRdEnOut, memAddrOut, wrDataOut, wrValidOut,
           busyOut, doneOut
  );

  modport master (
    output cmdAddrIn, cmdLenIn, cmdValidIn, memRdDataIn, wrReadyIn,
    input  cmdReadyOut, memRdEnOut, memAddrOut, wrDataOut, wrValidOut,
           busyOut, doneOut
  );
endinterface

// File: rtl/burst_read_streamer.sv
// Command-driven burst reader: sequential single-word reads from a fixed-latency
// memory, pushed into a stream FIFO. Define BURST_READ_STREAMER_STATS_EN for stallCountOut.
module burst_read_streamer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned LEN_WIDTH   = 16,
  parameter int unsigned ADDR_STEP   = 4,
  parameter int unsigned MEM_LATENCY = 2
) (
  input  logic                 clkIn,
  input  logic                 rstIn,
  burst_read_streamer_if.slave bus
`ifdef BURST_READ_STREAMER_STATS_EN
  ,
  output logic [31:0]          stallCountOut
`endif
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  curAddr;
  logic [LEN_WIDTH-1:0]   remaining;
  logic [MEM_LATENCY-1:0] inFlight;
  logic [MEM_LATENCY-1:0] inFlightNext;
  logic [DATA_WIDTH-1:0]  wrData;
  logic                   wrValid;
  logic                   done;
  logic                   issue;

  assign issue = (state == ISSUE) && bus.wrReadyIn;

  // Shift written bitwise so a single-stage pipeline needs no special case.
  always_comb begin
    inFlightNext    = inFlight << 1;
    inFlightNext[0] = issue;
  end

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      state     <= IDLE;
      curAddr   <= '0;
      remaining <= '0;
      inFlight  <= '0;
      wrData    <= '0;
      wrValid   <= 1'b0;
      done      <= 1'b0;
    end else begin
      inFlight <= inFlightNext;
      wrValid  <= inFlight[MEM_LATENCY-1];
      if (inFlight[MEM_LATENCY-1]) wrData <= bus.memRdDataIn;

      case (state)
        IDLE: begin
          if (bus.cmdValidIn) begin
            curAddr   <= bus.cmdAddrIn;
            remaining <= bus.cmdLenIn;
            state     <= (bus.cmdLenIn == '0) ? DONE : ISSUE;
          end
        end
        ISSUE: begin
          if (bus.wrReadyIn) begin
            curAddr   <= curAddr + ADDR_WIDTH'(ADDR_STEP);
            remaining <= remaining - 1'b1;
            if (remaining == LEN_WIDTH'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (inFlight == '0 && !wrValid) state <= DONE;
        end
        DONE: begin
          // First DONE cycle arms the pulse, second one presents it.
          if (done) begin
            done  <= 1'b0;
            state <= IDLE;
          end else begin
            done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef BURST_READ_STREAMER_STATS_EN
  logic [31:0] stallCount;

  always_ff @(posedge clkIn or posedge rstIn) begin
    if (rstIn) begin
      stallCount <= '0;
    end else if (state == IDLE && bus.cmdValidIn) begin
      stallCount <= '0;
    end else if (state == ISSUE && !bus.wrReadyIn && stallCount != '1) begin
      stallCount <= stallCount + 32'd1;
    end
  end

  assign stallCountOut = stallCount;
`endif

  assign bus.cmdReadyOut = (state == IDLE);
  assign bus.busyOut     = (state != IDLE);
  assign bus.memRdEnOut  = issue;
  assign bus.memAddrOut  = curAddr;
  assign bus.wrDataOut   = wrData;
  assign bus.wrValidOut  = wrValid;
  assign bus.doneOut     = done;

endmodule

// File: tb/tb_burst_read_streamer.sv
// Directed self-checking bench for burst_read_streamer with a 2-cycle memory model.
// Honours BURST_READ_STREAMER_STATS_EN when the design is built with it.
module tb_burst_read_streamer;

  logic clkIn = 1'b0;
  logic rstIn;

  burst_read_streamer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16)) bus ();

`ifdef BURST_READ_STREAMER_STATS_EN
  logic [31:0] stallCountOut;
`endif

  burst_read_streamer #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .LEN_WIDTH(16), .ADDR_STEP(4), .MEM_LATENCY(2)
  ) dut (
    .clkIn(clkIn),
    .rstIn(rstIn),
    .bus(bus)
`ifdef BURST_READ_STREAMER_STATS_EN
    ,
    .stallCountOut(stallCountOut)
`endif
  );

  always #5 clkIn = ~clkIn;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clkIn) cyc <= cyc + 1;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Fixed two-cycle read memory: data for a strobe in cycle k is valid in cycle k+2.
  logic [31:0] memD1;
  always @(posedge clkIn) begin
    memD1           <= bus.memRdEnOut ? memWord(bus.memAddrOut) : 32'hDEAD_BEEF;
    bus.memRdDataIn <= memD1;
  end

  logic [31:0] strobeAddr[$];
  int          strobeCyc[$];
  logic [31:0] wordQ[$];
  int          wordCyc[$];
  int          doneCyc[$];
  int          acceptCyc[$];
  int          busyCnt = 0;

  always @(negedge clkIn) begin
    if (!rstIn) begin
      if (bus.memRdEnOut) begin
        strobeAddr.push_back(bus.memAddrOut);
        strobeCyc.push_back(cyc);
      end
      if (bus.wrValidOut) begin
        wordQ.push_back(bus.wrDataOut);
        wordCyc.push_back(cyc);
      end
      if (bus.doneOut) doneCyc.push_back(cyc);
      if (bus.busyOut) busyCnt++;
      if (bus.cmdValidIn && bus.cmdReadyOut) acceptCyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issueCmd(input logic [31:0] addr, input logic [15:0] len);
    bus.cmdAddrIn  = addr;
    bus.cmdLenIn   = len;
    bus.cmdValidIn = 1'b1;
    @(posedge clkIn);
    #1;
    bus.cmdValidIn = 1'b0;
  endtask

  task automatic waitDone(input int n, input string tag);
    int k = 0;
    while (doneCyc.size() < n && k < 500) begin
      @(posedge clkIn);
      k++;
    end
    #1;
    check(tag, 64'(doneCyc.size()), 64'(n));
  endtask

  initial begin
    int s0, w0, d0, a0, b0, k;

    rstIn          = 1'b1;
    bus.cmdAddrIn  = '0;
    bus.cmdLenIn   = '0;
    bus.cmdValidIn = 1'b0;
    bus.wrReadyIn  = 1'b1;
    #1;
    check("rst_cmdReady", 64'(bus.cmdReadyOut), 64'd1);
    check("rst_memRdEn",  64'(bus.memRdEnOut),  64'd0);
    check("rst_wrValid",  64'(bus.wrValidOut),  64'd0);
    check("rst_busy",     64'(bus.busyOut),     64'd0);
    check("rst_done",     64'(bus.doneOut),     64'd0);
    check("rst_memAddr",  64'(bus.memAddrOut),  64'd0);
    repeat (3) @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    repeat (2) @(posedge clkIn);
    #1;

    // 1: four-word burst at 0x100 with the FIFO always ready
    s0 = strobeAddr.size(); w0 = wordQ.size(); d0 = doneCyc.size();
    issueCmd(32'h100, 16'd4);
    waitDone(d0 + 1, "t1_done_seen");
    repeat (2) @(posedge clkIn);
    #1;
    check("t1_strobes", 64'(strobeAddr.size() - s0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_addr%0d", i), 64'(strobeAddr[s0+i]), 64'(32'h100 + 32'(4*i)));
      check($sformatf("t1_strobeCyc%0d", i), 64'(strobeCyc[s0+i] - strobeCyc[s0]), 64'(i));
    end
    check("t1_words", 64'(wordQ.size() - w0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_data%0d", i), 64'(wordQ[w0+i]), 64'(memWord(32'h100 + 32'(4*i))));
      check($sformatf("t1_wordCyc%0d", i), 64'(wordCyc[w0+i] - wordCyc[w0]), 64'(i));
    end
    check("t1_latency", 64'(wordCyc[w0] - strobeCyc[s0]), 64'd3);
    check("t1_doneOnce", 64'(doneCyc.size() - d0), 64'd1);
    check("t1_doneAfterLast", 64'(doneCyc[d0] > wordCyc[w0+3]), 64'd1);

    // 2: zero-length command
    s0 = strobeAddr.size(); d0 = doneCyc.size(); a0 = acceptCyc.size(); b0 = busyCnt;
    issueCmd(32'h40, 16'd0);
    waitDone(d0 + 1, "t2_done_seen");
    check("t2_readyAfterDone", 64'(bus.cmdReadyOut), 64'd1);
    check("t2_doneCyc", 64'(doneCyc[d0] - acceptCyc[a0]), 64'd2);
    repeat (3) @(posedge clkIn);
    #1;
    check("t2_busyCycles", 64'(busyCnt - b0), 64'd2);
    check("t2_strobes", 64'(strobeAddr.size() - s0), 64'd0);

    // 3: eight words with a three-cycle FIFO stall after the third strobe
    s0 = strobeAddr.size(); w0 = wordQ.size(); d0 = doneCyc.size(); a0 = acceptCyc.size();
    issueCmd(32'h1000, 16'd8);
    repeat (3) @(posedge clkIn);
    #1;
    bus.wrReadyIn = 1'b0;
    repeat (3) @(posedge clkIn);
    #1;
    bus.wrReadyIn = 1'b1;
    waitDone(d0 + 1, "t3_done_seen");
    repeat (2) @(posedge clkIn);
    #1;
    check("t3_strobes", 64'(strobeAddr.size() - s0), 64'd8);
    check("t3_words", 64'(wordQ.size() - w0), 64'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t3_addr%0d", i), 64'(strobeAddr[s0+i]), 64'(32'h1000 + 32'(4*i)));
      check($sformatf("t3_data%0d", i), 64'(wordQ[w0+i]), 64'(memWord(32'h1000 + 32'(4*i))));
    end
    k = 0;
    for (int i = s0; i < strobeAddr.size(); i++)
      if (strobeCyc[i] >= acceptCyc[a0] + 4 && strobeCyc[i] <= acceptCyc[a0] + 6) k++;
    check("t3_noStrobeInStall", 64'(k), 64'd0);
    check("t3_resumeCyc", 64'(strobeCyc[s0+3] - acceptCyc[a0]), 64'd7);
`ifdef BURST_READ_STREAMER_STATS_EN
    check("t3_stallCount", 64'(stallCountOut), 64'd3);
`endif

    // 4: address wrap past 2^32
    s0 = strobeAddr.size(); w0 = wordQ.size(); d0 = doneCyc.size();
    issueCmd(32'hFFFF_FFF8, 16'd4);
`ifdef BURST_READ_STREAMER_STATS_EN
    check("t4_stallCleared", 64'(stallCountOut), 64'd0);
`endif
    waitDone(d0 + 1, "t4_done_seen");
    check("t4_strobes", 64'(strobeAddr.size() - s0), 64'd4);
    check("t4_addr0", 64'(strobeAddr[s0+0]), 64'h0000_0000_FFFF_FFF8);
    check("t4_addr1", 64'(strobeAddr[s0+1]), 64'h0000_0000_FFFF_FFFC);
    check("t4_addr2", 64'(strobeAddr[s0+2]), 64'h0000_0000_0000_0000);
    check("t4_addr3", 64'(strobeAddr[s0+3]), 64'h0000_0000_0000_0004);
    check("t4_data2", 64'(wordQ[w0+2]), 64'(memWord(32'h0)));

    // 5: asynchronous reset two cycles into a sixteen-word burst
    issueCmd(32'h200, 16'd16);
    repeat (2) @(posedge clkIn);
    #1;
    check("t5_busyBefore", 64'(bus.busyOut), 64'd1);
    rstIn = 1'b1;
    #1;
    check("t5_asyncRdEn",   64'(bus.memRdEnOut),  64'd0);
    check("t5_asyncAddr",   64'(bus.memAddrOut),  64'd0);
    check("t5_asyncBusy",   64'(bus.busyOut),     64'd0);
    check("t5_asyncValid",  64'(bus.wrValidOut),  64'd0);
    check("t5_asyncReady",  64'(bus.cmdReadyOut), 64'd1);
    repeat (2) @(posedge clkIn);
    #1;
    rstIn = 1'b0;
    s0 = strobeAddr.size(); w0 = wordQ.size(); b0 = busyCnt;
    repeat (10) @(posedge clkIn);
    #1;
    check("t5_noStrayWords", 64'(wordQ.size() - w0), 64'd0);
    check("t5_noStrobes", 64'(strobeAddr.size() - s0), 64'd0);
    check("t5_noBusy", 64'(busyCnt - b0), 64'd0);
    check("t5_readyAfter", 64'(bus.cmdReadyOut), 64'd1);

    // 6: command valid held high across a whole burst
    s0 = strobeAddr.size(); d0 = doneCyc.size(); a0 = acceptCyc.size();
    bus.cmdAddrIn  = 32'h300;
    bus.cmdLenIn   = 16'd2;
    bus.cmdValidIn = 1'b1;
    k = 0;
    while (acceptCyc.size() < a0 + 2 && k < 200) begin
      @(posedge clkIn);
      k++;
    end
    #1;
    bus.cmdValidIn = 1'b0;
    check("t6_twoAccepts", 64'(acceptCyc.size() - a0), 64'd2);
    waitDone(d0 + 2, "t6_done_seen");
    check("t6_secondAccept", 64'(acceptCyc[a0+1] - doneCyc[d0]), 64'd1);
    check("t6_strobes", 64'(strobeAddr.size() - s0), 64'd4);
    check("t6_addr2", 64'(strobeAddr[s0+2]), 64'h300);
    check("t6_addr3", 64'(strobeAddr[s0+3]), 64'h304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
